fdivider: RTL and testbench
===========================

FDIVIDER -- requirements
Module: fdivider

Interface
REQ-001 The block SHALL have no parameters; the format is fixed at IEEE-754 binary32.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 a  input  32  dividend, binary32.
REQ-006 b  input  32  divisor, binary32.
REQ-007 z  output  32  quotient a/b, binary32; registered.
REQ-008 busy  output  1  high from the accepting edge until the edge that asserts done.
REQ-009 done  output  1  one-cycle pulse; z is valid in that cycle.

Function
REQ-010 States SHALL be IDLE, UNPACK, SPECIAL, NORM, DIV, ALIGN, ROUND and PACK.
REQ-011 At edge E0, with start=1 in IDLE: capture a and b, set busy=1 and go to UNPACK.
- start while busy=1 is ignored.
- start held high after done starts a new operation at the next IDLE edge.
REQ-012 UNPACK: split sign, 8-bit exponent and 23-bit fraction.
- Internal exponents are 10-bit signed and unbiased.
- Exponent field 0 maps to -126 with no hidden bit; otherwise the hidden bit is 1.
REQ-013 SPECIAL, reached at edge E0+2, SHALL finish the operation on these cases, setting done=1 and busy=0:
- either operand NaN, 0/0 or inf/inf -> z=0xFFC00000;
- inf/finite or nonzero/0 -> signed inf;
- 0/nonzero or finite/inf -> signed zero.
- Sign is always a_s^b_s except for NaN.
REQ-014 NORM: on each edge, each mantissa whose bit 23 is 0 shifts left 1 and its exponent decrements.
- Both operands shift in parallel.
- When both bit 23s are set, go to DIV; NORM therefore lasts k+1 edges, where k is the larger leading-zero shift count.
REQ-015 DIV: 27-cycle restoring division, one quotient bit per edge, MSB first.
- Computes q[26:0] = floor((a_m<<26)/b_m) and remainder r.
- Result exponent z_e = a_e - b_e.
REQ-016 ALIGN: if q[26]=1, mantissa=q[26:3], guard=q[2], round=q[1], sticky=q[0]|(r!=0).
- Otherwise: mantissa=q[25:2], guard=q[1], round=q[0], sticky=(r!=0), and z_e decrements.
REQ-017 ALIGN, when z_e < -126, SHALL right-shift the mantissa by (-126 - z_e) in one cycle and set z_e=-126.
- Shifted-out bits feed guard, round and sticky.
- Shifts of 26 or more give mantissa 0 with sticky=1 if any bit was nonzero.
REQ-018 ROUND: round-to-nearest-even.
- Increment if guard & (round | sticky | mantissa[0]).
- A carry out of bit 23 sets mantissa=0x800000 and increments z_e.
REQ-019 PACK: z={sign, z_e+127, mantissa[22:0]}, with these exceptions:
- exponent field is 0 when z_e=-126 and mantissa[23]=0;
- z_e > 127 gives signed inf.
- PACK sets done=1 and busy=0.
REQ-020 Latency for a non-special operation SHALL be done asserted after edge E0+32+k; for normal operands (k=0) this is E0+32.
REQ-021 z SHALL hold its value until the next done; done SHALL be 0 in all other cycles.

Reset
REQ-022 With rst=1 at an edge: state=IDLE, z=0x00000000, busy=0, done=0, all internal registers cleared.
REQ-023 rst SHALL take priority over start and over every state, aborting any operation in flight with no done pulse.
REQ-024 start SHALL be accepted at the first edge after rst falls.

Verification
REQ-025 a=0x40C00000, b=0x40000000, start pulse -> z=0x40400000, done at E0+32, busy high for 32 cycles.
REQ-026 a=0x3F800000, b=0x40400000 -> z=0x3EAAAAAB (round-up path); a=0x7F7FFFFF, b=0x3F000000 -> z=0x7F800000 (overflow).
REQ-027 Specials -> each result at E0+2:
- a=0x3F800000, b=0x00000000 -> z=0x7F800000;
- a=0x00000000, b=0x00000000 -> z=0xFFC00000;
- a=0xFF800000, b=0x40000000 -> z=0xFF800000.
REQ-028 Subnormal in and out: a=0x00000001, b=0x3F800000 -> z=0x00000001, done at E0+55.
- a=0x00800000, b=0x40000000 -> z=0x00400000, done at E0+32.
REQ-029 Protocol:
- start pulses while busy are ignored (no extra done).
- rst asserted at E0+10 -> busy=0, done never pulses, z=0.
- Back-to-back starts give two done pulses, 33 edges apart.

Source files
------------

// File: rtl/fdivider.sv
// IEEE-754 binary32 divider, multi-cycle.
// Restoring division producing one quotient bit per cycle, round-to-nearest-even,
// with gradual underflow on input and output and a short path for special operands.
module fdivider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] z,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UNPACK  = 3'd1,
        SPECIAL = 3'd2,
        NORM    = 3'd3,
        DIV     = 3'd4,
        ALIGN   = 3'd5,
        ROUND   = 3'd6,
        PACK    = 3'd7
    } state_t;

    state_t             state_r, state_s;
    logic [31:0]        a_r, a_s, b_r, b_s;
    logic               sign_r, sign_s;
    logic [23:0]        a_m_r, a_m_s, b_m_r, b_m_s;
    logic signed [9:0]  a_e_r, a_e_s, b_e_r, b_e_s, z_e_r, z_e_s;
    logic [26:0]        q_r, q_s;
    logic [24:0]        rem_r, rem_s;
    logic [4:0]         cnt_r, cnt_s;
    logic [23:0]        m_r, m_s;
    logic               g_r, g_s, rd_r, rd_s, st_r, st_s;
    logic [31:0]        z_r, z_s;
    logic               busy_r, busy_s, done_r, done_s;

    // special-operand classification
    logic               a_nan_s, a_inf_s, a_zero_s, b_nan_s, b_inf_s, b_zero_s;
    logic               spec_hit_s;
    logic [31:0]        spec_z_s;
    // one restoring-division step
    logic               div_ge_s;
    logic [24:0]        div_diff_s, div_rem_s;
    // quotient alignment and underflow denormalisation
    logic [23:0]        al_m_s;
    logic               al_g_s, al_r_s, al_st_s;
    logic signed [9:0]  al_e_s, sh_full_s;
    logic [4:0]         sh_c_s;
    logic [51:0]        wide_s;
    // rounding
    logic               inc_s;
    logic [24:0]        sum_s;
    logic [23:0]        rnd_m_s;
    logic signed [9:0]  rnd_e_s;

    // Assemble the binary32 word from sign, unbiased exponent and 24-bit mantissa.
    // A mantissa without its hidden bit is only produced at exponent -126.
    function automatic logic [31:0] pack_result(input logic sgn,
                                                input logic signed [9:0] e,
                                                input logic [23:0] m);
        logic [7:0] biased;
        biased = e[7:0] + 8'd127;
        if (e > 10'sd127) begin
            pack_result = {sgn, 8'hFF, 23'd0};
        end else if (!m[23]) begin
            pack_result = {sgn, 8'd0, m[22:0]};
        end else begin
            pack_result = {sgn, biased, m[22:0]};
        end
    endfunction

    // Classify captured operands and pick the short-path result.
    always_comb begin
        a_nan_s  = (&a_r[30:23]) & (|a_r[22:0]);
        a_inf_s  = (&a_r[30:23]) & ~(|a_r[22:0]);
        a_zero_s = ~(|a_r[30:0]);
        b_nan_s  = (&b_r[30:23]) & (|b_r[22:0]);
        b_inf_s  = (&b_r[30:23]) & ~(|b_r[22:0]);
        b_zero_s = ~(|b_r[30:0]);
        if (a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s)) begin
            spec_hit_s = 1'b1;
            spec_z_s   = 32'hFFC00000;
        end else if (a_inf_s | b_zero_s) begin
            spec_hit_s = 1'b1;
            spec_z_s   = {sign_r, 8'hFF, 23'd0};
        end else if (a_zero_s | b_inf_s) begin
            spec_hit_s = 1'b1;
            spec_z_s   = {sign_r, 31'd0};
        end else begin
            spec_hit_s = 1'b0;
            spec_z_s   = 32'd0;
        end
    end

    // Trial subtraction for the current quotient bit.
    always_comb begin
        div_ge_s   = (rem_r >= {1'b0, b_m_r});
        div_diff_s = rem_r - {1'b0, b_m_r};
        if (div_ge_s) begin
            div_rem_s = div_diff_s;
        end else begin
            div_rem_s = rem_r;
        end
    end

    // Select the 24 mantissa bits from the quotient, then denormalise if the exponent underflows.
    always_comb begin
        if (q_r[26]) begin
            al_m_s  = q_r[26:3];
            al_g_s  = q_r[2];
            al_r_s  = q_r[1];
            al_st_s = q_r[0] | (rem_r != 25'd0);
            al_e_s  = z_e_r;
        end else begin
            al_m_s  = q_r[25:2];
            al_g_s  = q_r[1];
            al_r_s  = q_r[0];
            al_st_s = (rem_r != 25'd0);
            al_e_s  = z_e_r - 10'sd1;
        end
        sh_full_s = -10'sd126 - al_e_s;
        // A 26-bit shift already moves every bit into the sticky field; clamp there.
        if (sh_full_s > 10'sd26) begin
            sh_c_s = 5'd26;
        end else if (sh_full_s < 10'sd0) begin
            sh_c_s = 5'd0;
        end else begin
            sh_c_s = sh_full_s[4:0];
        end
        wide_s = {al_m_s, al_g_s, al_r_s, 26'd0} >> sh_c_s;
    end

    // Round-to-nearest-even increment with mantissa carry handling.
    always_comb begin
        inc_s = g_r & (rd_r | st_r | m_r[0]);
        sum_s = {1'b0, m_r} + {24'd0, inc_s};
        if (sum_s[24]) begin
            rnd_m_s = 24'h800000;
            rnd_e_s = z_e_r + 10'sd1;
        end else begin
            rnd_m_s = sum_s[23:0];
            rnd_e_s = z_e_r;
        end
    end

    // Next-state and next-datapath values for every state.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        sign_s  = sign_r;
        a_m_s   = a_m_r;
        b_m_s   = b_m_r;
        a_e_s   = a_e_r;
        b_e_s   = b_e_r;
        z_e_s   = z_e_r;
        q_s     = q_r;
        rem_s   = rem_r;
        cnt_s   = cnt_r;
        m_s     = m_r;
        g_s     = g_r;
        rd_s    = rd_r;
        st_s    = st_r;
        z_s     = z_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            // PACK is the cycle the result is presented; it accepts a new request just like IDLE.
            IDLE, PACK: begin
                if (start) begin
                    a_s     = a;
                    b_s     = b;
                    busy_s  = 1'b1;
                    state_s = UNPACK;
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            UNPACK: begin
                sign_s  = a_r[31] ^ b_r[31];
                a_m_s   = {|a_r[30:23], a_r[22:0]};
                b_m_s   = {|b_r[30:23], b_r[22:0]};
                if (a_r[30:23] == 8'd0) begin
                    a_e_s = -10'sd126;
                end else begin
                    a_e_s = {2'b00, a_r[30:23]} - 10'd127;
                end
                if (b_r[30:23] == 8'd0) begin
                    b_e_s = -10'sd126;
                end else begin
                    b_e_s = {2'b00, b_r[30:23]} - 10'd127;
                end
                state_s = SPECIAL;
            end
            SPECIAL: begin
                if (spec_hit_s) begin
                    z_s     = spec_z_s;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = NORM;
                end
            end
            NORM: begin
                if (a_m_r[23] & b_m_r[23]) begin
                    z_e_s   = a_e_r - b_e_r;
                    rem_s   = {1'b0, a_m_r};
                    q_s     = 27'd0;
                    cnt_s   = 5'd0;
                    state_s = DIV;
                end else begin
                    if (!a_m_r[23]) begin
                        a_m_s = a_m_r << 1;
                        a_e_s = a_e_r - 10'sd1;
                    end else begin
                        a_m_s = a_m_r;
                        a_e_s = a_e_r;
                    end
                    if (!b_m_r[23]) begin
                        b_m_s = b_m_r << 1;
                        b_e_s = b_e_r - 10'sd1;
                    end else begin
                        b_m_s = b_m_r;
                        b_e_s = b_e_r;
                    end
                    state_s = NORM;
                end
            end
            DIV: begin
                q_s   = {q_r[25:0], div_ge_s};
                rem_s = div_rem_s << 1;
                cnt_s = cnt_r + 5'd1;
                if (cnt_r == 5'd26) begin
                    state_s = ALIGN;
                end else begin
                    state_s = DIV;
                end
            end
            ALIGN: begin
                if (al_e_s < -10'sd126) begin
                    m_s   = wide_s[51:28];
                    g_s   = wide_s[27];
                    rd_s  = wide_s[26];
                    st_s  = al_st_s | (|wide_s[25:0]);
                    z_e_s = -10'sd126;
                end else begin
                    m_s   = al_m_s;
                    g_s   = al_g_s;
                    rd_s  = al_r_s;
                    st_s  = al_st_s;
                    z_e_s = al_e_s;
                end
                state_s = ROUND;
            end
            ROUND: begin
                m_s     = rnd_m_s;
                z_e_s   = rnd_e_s;
                z_s     = pack_result(sign_r, rnd_e_s, rnd_m_s);
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = PACK;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            sign_r  <= 1'b0;
            a_m_r   <= 24'd0;
            b_m_r   <= 24'd0;
            a_e_r   <= 10'sd0;
            b_e_r   <= 10'sd0;
            z_e_r   <= 10'sd0;
            q_r     <= 27'd0;
            rem_r   <= 25'd0;
            cnt_r   <= 5'd0;
            m_r     <= 24'd0;
            g_r     <= 1'b0;
            rd_r    <= 1'b0;
            st_r    <= 1'b0;
            z_r     <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            sign_r  <= sign_s;
            a_m_r   <= a_m_s;
            b_m_r   <= b_m_s;
            a_e_r   <= a_e_s;
            b_e_r   <= b_e_s;
            z_e_r   <= z_e_s;
            q_r     <= q_s;
            rem_r   <= rem_s;
            cnt_r   <= cnt_s;
            m_r     <= m_s;
            g_r     <= g_s;
            rd_r    <= rd_s;
            st_r    <= st_s;
            z_r     <= z_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign z    = z_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_fdivider.sv
// Scoreboard bench for fdivider: stimulus pushes expected results, a monitor pops them on done.
module tb_fdivider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b, z;
    logic        busy, done;

    always #5 clk = ~clk;

    fdivider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .z     (z),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [31:0] z;
        int          e0;
        int          done_edge;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;

    always @(posedge clk) edges <= edges + 1;

    // Reference: exact rational quotient rounded to nearest-even in units of the result ulp.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] zr, output int lat);
        logic         sgn, xnan, xinf, xzero, ynan, yinf, yzero;
        logic [23:0]  mx, my;
        int           ex, ey, lx, ly, e_res, sh;
        logic [127:0] num, den, n, rm;
        sgn   = x[31] ^ y[31];
        xnan  = (&x[30:23]) && (|x[22:0]);
        xinf  = (&x[30:23]) && !(|x[22:0]);
        xzero = (x[30:0] == 31'd0);
        ynan  = (&y[30:23]) && (|y[22:0]);
        yinf  = (&y[30:23]) && !(|y[22:0]);
        yzero = (y[30:0] == 31'd0);
        lat = 2;
        if (xnan || ynan || (xzero && yzero) || (xinf && yinf)) begin
            zr = 32'hFFC00000;
        end else if (xinf || yzero) begin
            zr = {sgn, 8'hFF, 23'd0};
        end else if (xzero || yinf) begin
            zr = {sgn, 31'd0};
        end else begin
            mx = {|x[30:23], x[22:0]};
            my = {|y[30:23], y[22:0]};
            ex = (x[30:23] == 8'd0) ? -126 : int'(x[30:23]) - 127;
            ey = (y[30:23] == 8'd0) ? -126 : int'(y[30:23]) - 127;
            lx = 0;
            ly = 0;
            while (!mx[23]) begin mx = mx << 1; ex--; lx++; end
            while (!my[23]) begin my = my << 1; ey--; ly++; end
            lat   = 32 + ((lx > ly) ? lx : ly);
            e_res = ex - ey - ((mx < my) ? 1 : 0);
            if (e_res < -126) e_res = -126;
            sh = ex - ey - e_res + 23;
            if (sh < -60) begin
                n = 128'd0;
            end else begin
                if (sh >= 0) begin
                    num = 128'(mx) << sh;
                    den = 128'(my);
                end else begin
                    num = 128'(mx);
                    den = 128'(my) << (-sh);
                end
                n  = num / den;
                rm = num % den;
                if ((2 * rm > den) || ((2 * rm == den) && n[0])) n = n + 128'd1;
            end
            if (n == 128'h1000000) begin
                n = 128'h800000;
                e_res++;
            end
            if (e_res > 127) zr = {sgn, 8'hFF, 23'd0};
            else if (n < 128'h800000) zr = {sgn, 8'd0, n[22:0]};
            else zr = {sgn, 8'(e_res + 127), n[22:0]};
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int          kind;
        kind = $urandom_range(0, 11);
        v    = $urandom;
        case (kind)
            0: v[30:0] = 31'd0;
            1: v[30:0] = {8'hFF, 23'd0};
            2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3: begin v[30:23] = 8'd0; if (v[22:0] == 23'd0) v[0] = 1'b1; end
            4: begin v[30:23] = 8'd0; v[22:0] = 23'($urandom_range(1, 255)); end
            5, 6: v = v;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Issue one request at the next idle edge; expected value from the model or a constant.
    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input bit use_model, input logic [31:0] zc, input int latc);
        int          n;
        exp_t        e;
        logic [31:0] zm;
        int          lm;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_busy", {31'd0, busy}, 32'd0);
        if (use_model) begin
            ref_div(x, y, zm, lm);
        end else begin
            zm = zc;
            lm = latc;
        end
        a     = x;
        b     = y;
        start = 1'b1;
        e.z         = zm;
        e.e0        = edges + 1;
        e.done_edge = e.e0 + lm;
        e.a         = x;
        e.b         = y;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compare result and completion edge on every done, and busy on every cycle.
    initial begin
        exp_t e;
        logic exp_busy;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 at edge %0d, required 0", edges);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (z !== e.z) begin
                        errors++;
                        $display("FAIL result: %h/%h got z=%h, required %h", e.a, e.b, z, e.z);
                    end
                    checks++;
                    if (edges != e.done_edge) begin
                        errors++;
                        $display("FAIL latency: %h/%h done at edge %0d, required %0d",
                                 e.a, e.b, edges, e.done_edge);
                    end
                end
            end
            exp_busy = (sb.size() != 0) && (sb[0].e0 <= edges);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                if (errors < 40)
                    $display("FAIL busy: edge %0d got %b, required %b", edges, busy, exp_busy);
            end
        end
    end

    logic [31:0] dir_a [8] = '{32'h40C00000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000,
                               32'h00000000, 32'hFF800000, 32'h00000001, 32'h00800000};
    logic [31:0] dir_b [8] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000,
                               32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000};
    logic [31:0] dir_z [8] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7F800000,
                               32'hFFC00000, 32'hFF800000, 32'h00000001, 32'h00400000};
    int          dir_l [8] = '{32, 32, 32, 2, 2, 2, 55, 32};

    initial begin
        int   n;
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_z", z, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // Directed vectors with fixed expectations (issued back to back).
        for (int i = 0; i < 8; i++) issue(dir_a[i], dir_b[i], 1'b0, dir_z[i], dir_l[i]);

        // start pulses while busy must be ignored.
        issue(32'h41200000, 32'h40400000, 1'b1, 32'd0, 0);
        repeat (5) @(negedge clk);
        a = $urandom; b = $urandom; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;

        // start held high: a second operation begins on the cycle after done.
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        e.z = 32'h40400000; e.a = a; e.b = b;
        e.e0 = edges + 1;       e.done_edge = e.e0 + 32; sb.push_back(e);
        e.e0 = edges + 1 + 33;  e.done_edge = e.e0 + 32; sb.push_back(e);
        repeat (34) @(negedge clk);
        start = 1'b0;

        // Reset in flight at E0+10 aborts the operation with no done pulse.
        issue(32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 32);
        repeat (9) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_z", z, 32'd0);
        // Request accepted at the first edge after reset is released.
        rst = 1'b0;
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        e.z = 32'h40400000; e.a = a; e.b = b;
        e.e0 = edges + 1; e.done_edge = e.e0 + 32; sb.push_back(e);
        @(negedge clk);
        start = 1'b0;

        // Randomised operands checked against the reference model.
        repeat (150) begin
            issue(rand_operand(), rand_operand(), 1'b1, 32'd0, 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
